alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised successor to the single-cycle integer ALU. It executes the full RV32I ALU operation set in one cycle and adds the RV32M multiply/divide instructions as iterative operations. Operation select is the same opcode/func3/func7 decode as the base ALU, and all results are registered. It sits in the multicycle datapath's execute stage, and the control FSM sequences around it with a start/done handshake.

## Interface
- WIDTH, 32: datapath width. Must be even and ≥ 8. Shift amount is the low $clog2(WIDTH) bits of data_in_2.
- M_EXT, 1: 1 enables the mul/div unit. With 0, every func7=0000001 op under opcode 0110011 returns 0 in one cycle.

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- data_in_1  in  WIDTH  operand A (rs1 or PC)
- data_in_2  in  WIDTH  operand B (rs2 or immediate)
- func3  in  3  instruction func3
- func7  in  7  instruction func7
- opcode  in  7  instruction opcode
- data_out  out  WIDTH  registered result; held until the next accepted start completes
- zero  out  1  registered (data_out == 0)
- comparison  out  1  registered branch-condition result
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse: data_out, zero and comparison are valid

## Operation
- **Single-cycle ops** (RV32I group):
  - Opcodes 0010011 and 0110011 with func7≠0000001: add/sub, sll, slt, sltu, xor, srl/sra (func7=0100000 selects sub/sra), or, and.
  - 0100011, 0000011, 1100111, 0010111: signed A+B.
  - 0110111: B.
  - 1100011: comparison per func3 (beq, bne, blt, bge, bltu, bgeu); data_out=0. Undefined func3 gives comparison=0.
  - Any other opcode: data_out=0, comparison=0.
- **M ops** (opcode 0110011, func7=0000001, M_EXT=1):
  - func3 000 MUL: low WIDTH bits of the product.
  - 001 MULH: high bits, signed×signed.
  - 010 MULHSU: high bits, signed×unsigned.
  - 011 MULHU: high bits, unsigned×unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- **Mul**: operands are converted to magnitudes and latched. Shift-add runs one bit per cycle over WIDTH cycles into a 2·WIDTH accumulator. The product is negated at the end if exactly one signed operand was negative.
- **Div**: restoring division on magnitudes, one quotient bit per cycle over WIDTH cycles. The quotient is negated if the operand signs differ (signed ops). The remainder takes the sign of the dividend.
- **Special cases** are resolved in one cycle without iterating:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (A = most-negative, B = −1) for DIV/REM: quotient = A; remainder = 0.
- comparison=0 for every non-branch op.
- **FSM states**: IDLE, RUN, DONE.
  - IDLE or DONE with start=1 and an iterative op → RUN. Operands and op are latched; the bit counter is loaded with WIDTH.
  - IDLE or DONE with start=1 and a single-cycle or special-case op → DONE. The result is registered.
  - IDLE or DONE with start=0 → IDLE.
  - RUN → RUN while counter>1, decrementing each cycle. When counter=1, the result is registered and the FSM goes to DONE.
- busy=1 exactly in RUN. done=1 exactly in DONE.
- start while busy=1 is ignored and not queued. Inputs may change freely during RUN because the latched copies are used.
- data_out, zero and comparison update only on the cycle that enters DONE.

## Timing
- Start accepted at edge T.
- Single-cycle op: done=1 in cycle T+1.
- Iterative op: busy=1 in cycles T+1 through T+WIDTH; done=1 in cycle T+WIDTH+1.
- Back-to-back: a start sampled during the DONE cycle is accepted. Single-cycle ops therefore sustain one result per cycle.
- **Reset** (synchronous, any state including mid-RUN):
  - Next cycle: state=IDLE, data_out=0, zero=1, comparison=0, busy=0, done=0.
  - An aborted operation never produces done.

## Test plan
- **Reset, then ADDI**: rst for 2 cycles; then start with opcode 0010011, func3 000, A=5, B=0xFFFFFFF9. Required: outputs 0/1/0/0/0 after reset; done in T+1 with data_out=0xFFFFFFFE, zero=0.
- **MUL and MULH**: A=0xFFFFFFFF, B=3.
  - MUL: busy high for cycles T+1..T+32; done in T+33 with data_out=0xFFFFFFFD.
  - MULH: data_out=0xFFFFFFFF.
  - MULHU: data_out=0x00000002.
- **Signed divide**: A=0xFFFFFFF9 (−7), B=2.
  - DIV: 0xFFFFFFFD after 33 cycles.
  - REM: 0xFFFFFFFF.
  - DIVU with A=100, B=7: 14.
  - REMU with A=100, B=7: 2.
- **Special cases**, each with done in T+1 and busy never asserted:
  - DIVU 10/0 → 0xFFFFFFFF; REMU 10/0 → 10.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0, zero=1.
- **Branch compare**:
  - BLT with A=0xFFFFFFFF, B=1: comparison=1, data_out=0.
  - BLTU with the same operands: comparison=0.
  - BEQ with A=B=7: comparison=1.
- **Handshake and reset abort**:
  - A start pulse and changed operands during RUN are ignored; the original result is delivered at T+33.
  - A new start in the DONE cycle is accepted.
  - rst asserted at T+10 of a DIV: next cycle IDLE with all outputs at reset values, and no done pulse follows.

Source files
------------

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// alu_mc : multi-cycle RV32I/RV32M ALU with start/busy/done handshake
// Revision: 1.0
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int M_EXT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in_1,
  input  logic [WIDTH-1:0] data_in_2,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [6:0]       opcode,
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic             comparison,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     bmag_q, bmag_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 negr_q, negr_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 zero_q, zero_d;
  logic                 cmp_q, cmp_d;

  logic                 w_is_m, w_is_div, w_sgn_div, w_b_zero, w_ovf;
  logic                 w_special, w_iter, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag;
  logic [SW-1:0]        w_shamt;
  logic [WIDTH-1:0]     w_alu_res;
  logic                 w_alu_cmp;
  logic [WIDTH:0]       w_mul_sum, w_rem_sh;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_rem_diff, w_quot, w_rem, w_iter_res;
  logic [2*WIDTH-1:0]   w_step, w_prod;

  assign w_shamt = data_in_2[SW-1:0];

  always_comb begin
    w_is_m    = (M_EXT != 0) && (opcode == OPC_OP) && (func7 == F7_MULDIV);
    w_is_div  = func3[2];
    w_sgn_div = w_is_div && !func3[0];
    w_b_zero  = (data_in_2 == '0);
    w_ovf     = w_sgn_div && (data_in_1 == MOST_NEG) && (data_in_2 == '1);
    w_special = w_is_m && w_is_div && (w_b_zero || w_ovf);
    w_iter    = w_is_m && !w_special;
    // MULH/MULHSU take A as signed, only MULH takes B as signed; MUL low half is sign-agnostic
    w_a_neg   = data_in_1[WIDTH-1] &&
                (w_is_div ? w_sgn_div : ((func3[1:0] == 2'b01) || (func3[1:0] == 2'b10)));
    w_b_neg   = data_in_2[WIDTH-1] && (w_is_div ? w_sgn_div : (func3[1:0] == 2'b01));
    w_a_mag   = w_a_neg ? -data_in_1 : data_in_1;
    w_b_mag   = w_b_neg ? -data_in_2 : data_in_2;
  end

  always_comb begin
    w_alu_res = '0;
    w_alu_cmp = 1'b0;
    case (opcode)
      OPC_OP_IMM, OPC_OP: begin
        if ((opcode == OPC_OP) && (func7 == F7_MULDIV)) begin
          if (w_special) begin
            if (w_b_zero) w_alu_res = func3[1] ? data_in_1 : '1;
            else          w_alu_res = func3[1] ? '0 : data_in_1;
          end
        end else begin
          case (func3)
            3'b000: w_alu_res = (func7 == F7_ALT) ? (data_in_1 - data_in_2)
                                                  : (data_in_1 + data_in_2);
            3'b001: w_alu_res = data_in_1 << w_shamt;
            3'b010: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(data_in_1) < $signed(data_in_2))};
            3'b011: w_alu_res = {{(WIDTH-1){1'b0}}, (data_in_1 < data_in_2)};
            3'b100: w_alu_res = data_in_1 ^ data_in_2;
            3'b101: begin
              if (func7 == F7_ALT) w_alu_res = $signed(data_in_1) >>> w_shamt;
              else                 w_alu_res = data_in_1 >> w_shamt;
            end
            3'b110: w_alu_res = data_in_1 | data_in_2;
            default: w_alu_res = data_in_1 & data_in_2;
          endcase
        end
      end
      OPC_STORE, OPC_LOAD, OPC_JALR, OPC_AUIPC: w_alu_res = data_in_1 + data_in_2;
      OPC_LUI: w_alu_res = data_in_2;
      OPC_BRANCH: begin
        case (func3)
          3'b000:  w_alu_cmp = (data_in_1 == data_in_2);
          3'b001:  w_alu_cmp = (data_in_1 != data_in_2);
          3'b100:  w_alu_cmp = ($signed(data_in_1) <  $signed(data_in_2));
          3'b101:  w_alu_cmp = ($signed(data_in_1) >= $signed(data_in_2));
          3'b110:  w_alu_cmp = (data_in_1 <  data_in_2);
          3'b111:  w_alu_cmp = (data_in_1 >= data_in_2);
          default: w_alu_cmp = 1'b0;
        endcase
      end
      default: begin
        w_alu_res = '0;
        w_alu_cmp = 1'b0;
      end
    endcase
  end

  // acc_q holds {high, low}: product/multiplier for mul, remainder/quotient for div
  always_comb begin
    w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
    w_rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    w_qbit     = (w_rem_sh >= {1'b0, bmag_q});
    w_rem_diff = w_rem_sh[WIDTH-1:0] - bmag_q;
    if (op_q[2]) begin
      w_step = {(w_qbit ? w_rem_diff : w_rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], w_qbit};
    end else begin
      w_step = {w_mul_sum, acc_q[WIDTH-1:1]};
    end
    w_prod = neg_q  ? -w_step : w_step;
    w_quot = neg_q  ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
    w_rem  = negr_q ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
    if (op_q[2]) begin
      w_iter_res = op_q[1] ? w_rem : w_quot;
    end else begin
      w_iter_res = (op_q[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bmag_d  = bmag_q;
    op_d    = op_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    out_d   = out_q;
    zero_d  = zero_q;
    cmp_d   = cmp_q;
    case (state_q)
      S_RUN: begin
        acc_d = w_step;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          out_d   = w_iter_res;
          zero_d  = (w_iter_res == '0);
          cmp_d   = 1'b0;
        end
      end
      default: begin
        if (start) begin
          if (w_iter) begin
            state_d = S_RUN;
            cnt_d   = CNT_LOAD;
            acc_d   = {{WIDTH{1'b0}}, w_a_mag};
            bmag_d  = w_b_mag;
            op_d    = func3;
            neg_d   = w_a_neg ^ w_b_neg;
            negr_d  = w_a_neg;
          end else begin
            state_d = S_DONE;
            out_d   = w_alu_res;
            zero_d  = (w_alu_res == '0);
            cmp_d   = w_alu_cmp;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      bmag_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bmag_q  <= bmag_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      cmp_q   <= cmp_d;
    end
  end

  assign data_out   = out_q;
  assign zero       = zero_q;
  assign comparison = cmp_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// tb_alu_mc : directed + randomized checks of alu_mc against an arithmetic model
// Revision: 1.0
// ============================================================================
module tb_alu_mc;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic        clk, rst, start;
  logic [31:0] data_in_1, data_in_2;
  logic [2:0]  func3;
  logic [6:0]  func7, opcode;
  logic [31:0] data_out;
  logic        zero, comparison, busy, done;

  int checks   = 0;
  int failures = 0;

  alu_mc #(.WIDTH(32), .M_EXT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in_1  (data_in_1),
    .data_in_2  (data_in_2),
    .func3      (func3),
    .func7      (func7),
    .opcode     (opcode),
    .data_out   (data_out),
    .zero       (zero),
    .comparison (comparison),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {comparison, data_out} straight from the instruction semantics.
  function automatic logic [32:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    logic        c;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    r = 32'h0;
    c = 1'b0;
    p = 64'sh0;
    if (opc == OPC_OP && f7 == F7_MULDIV) begin
      case (f3)
        3'd0: begin p = sa * sb; r = p[31:0];  end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * ub; r = p[63:32]; end
        3'd3: begin p = ua * ub; r = p[63:32]; end
        3'd4: begin
          if (b == 0) r = 32'hFFFFFFFF;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
          else begin p = sa / sb; r = p[31:0]; end
        end
        3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
        3'd6: begin
          if (b == 0) r = a;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
          else begin p = sa % sb; r = p[31:0]; end
        end
        default: r = (b == 0) ? a : a % b;
      endcase
    end else if (opc == OPC_OP || opc == OPC_OP_IMM) begin
      case (f3)
        3'd0: r = (f7 == F7_ALT) ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: begin
          p = sa >>> b[4:0];
          r = (f7 == F7_ALT) ? p[31:0] : a >> b[4:0];
        end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (opc == 7'b0100011 || opc == 7'b0000011 || opc == 7'b1100111 ||
                 opc == 7'b0010111) begin
      r = a + b;
    end else if (opc == 7'b0110111) begin
      r = b;
    end else if (opc == OPC_BRANCH) begin
      case (f3)
        3'd0: c = (a == b);
        3'd1: c = (a != b);
        3'd4: c = (sa < sb);
        3'd5: c = (sa >= sb);
        3'd6: c = (a < b);
        3'd7: c = (a >= b);
        default: c = 1'b0;
      endcase
    end
    return {c, r};
  endfunction

  function automatic bit iterative(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] a,
                                   input logic [31:0] b);
    bit special;
    special = f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    return (opc == OPC_OP) && (f7 == F7_MULDIV) && !special;
  endfunction

  // Entered and left at posedge+1; leaves the bench sitting in the done cycle.
  task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] e;
    int lat, nbusy, exp_lat;
    e       = model(opc, f3, f7, a, b);
    exp_lat = iterative(opc, f3, f7, a, b) ? 33 : 1;
    opcode = opc; func3 = f3; func7 = f7; data_in_1 = a; data_in_2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(nbusy), (exp_lat == 33) ? 32'd32 : 32'd0);
    check({tag, " data_out"}, data_out, e[31:0]);
    check({tag, " zero"}, {31'h0, zero}, {31'h0, (e[31:0] == 32'h0)});
    check({tag, " comparison"}, {31'h0, comparison}, {31'h0, e[32]});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0]  opcs [10];
    logic [32:0] e;
    logic [6:0]  ro, rf7;
    logic [2:0]  rf3;
    int lat, nd;
    opcs = '{7'b0010011, 7'b0110011, 7'b0100011, 7'b0000011, 7'b1100111,
             7'b0010111, 7'b0110111, 7'b1100011, 7'b1111111, 7'b0110011};

    rst = 1'b1; start = 1'b0; data_in_1 = 0; data_in_2 = 0;
    func3 = 0; func7 = 0; opcode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset data_out", data_out, 32'h0);
    check("reset zero", {31'h0, zero}, 32'd1);
    check("reset comparison", {31'h0, comparison}, 32'd0);
    check("reset busy", {31'h0, busy}, 32'd0);
    check("reset done", {31'h0, done}, 32'd0);

    run_op("addi", OPC_OP_IMM, 3'd0, 7'h0, 32'd5, 32'hFFFFFFF9);
    check("addi const", data_out, 32'hFFFFFFFE);

    run_op("mul",   OPC_OP, 3'd0, F7_MULDIV, 32'hFFFFFFFF, 32'd3);
    check("mul const", data_out, 32'hFFFFFFFD);
    run_op("mulh",  OPC_OP, 3'd1, F7_MULDIV, 32'hFFFFFFFF, 32'd3);
    run_op("mulhu", OPC_OP, 3'd3, F7_MULDIV, 32'hFFFFFFFF, 32'd3);
    check("mulhu const", data_out, 32'h2);

    run_op("div",  OPC_OP, 3'd4, F7_MULDIV, 32'hFFFFFFF9, 32'd2);
    check("div const", data_out, 32'hFFFFFFFD);
    run_op("rem",  OPC_OP, 3'd6, F7_MULDIV, 32'hFFFFFFF9, 32'd2);
    run_op("divu", OPC_OP, 3'd5, F7_MULDIV, 32'd100, 32'd7);
    run_op("remu", OPC_OP, 3'd7, F7_MULDIV, 32'd100, 32'd7);
    check("remu const", data_out, 32'd2);

    run_op("divu0", OPC_OP, 3'd5, F7_MULDIV, 32'd10, 32'd0);
    run_op("remu0", OPC_OP, 3'd7, F7_MULDIV, 32'd10, 32'd0);
    run_op("divov", OPC_OP, 3'd4, F7_MULDIV, 32'h80000000, 32'hFFFFFFFF);
    run_op("remov", OPC_OP, 3'd6, F7_MULDIV, 32'h80000000, 32'hFFFFFFFF);
    check("remov zero const", {31'h0, zero}, 32'd1);

    run_op("blt",  OPC_BRANCH, 3'd4, 7'h0, 32'hFFFFFFFF, 32'd1);
    run_op("bltu", OPC_BRANCH, 3'd6, 7'h0, 32'hFFFFFFFF, 32'd1);
    run_op("beq",  OPC_BRANCH, 3'd0, 7'h0, 32'd7, 32'd7);
    check("beq const", {31'h0, comparison}, 32'd1);

    // Start pulse and operand changes mid-RUN must not disturb the running DIV.
    e = model(OPC_OP, 3'd4, F7_MULDIV, 32'd1000, 32'hFFFFFFFD);
    opcode = OPC_OP; func3 = 3'd4; func7 = F7_MULDIV;
    data_in_1 = 32'd1000; data_in_2 = 32'hFFFFFFFD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    opcode = OPC_OP_IMM; func3 = 3'd0; func7 = 7'h0;
    data_in_1 = 32'd5; data_in_2 = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    lat++; start = 1'b0; data_in_1 = $urandom; data_in_2 = $urandom;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("ignore latency", 32'(lat), 32'd33);
    check("ignore data_out", data_out, e[31:0]);
    @(posedge clk); #1;
    check("ignore no second done", {31'h0, done}, 32'd0);
    check("ignore idle busy", {31'h0, busy}, 32'd0);

    // Reset during DIV at T+10 aborts it without a done pulse.
    opcode = OPC_OP; func3 = 3'd4; func7 = F7_MULDIV;
    data_in_1 = 32'd12345; data_in_2 = 32'd77; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("abort busy before rst", {31'h0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort data_out", data_out, 32'h0);
    check("abort zero", {31'h0, zero}, 32'd1);
    check("abort comparison", {31'h0, comparison}, 32'd0);
    check("abort busy", {31'h0, busy}, 32'd0);
    check("abort done", {31'h0, done}, 32'd0);
    nd = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) nd++; end
    check("abort no done", 32'(nd), 32'd0);

    for (int i = 0; i < 40; i++) begin
      ro  = opcs[$urandom_range(0, 9)];
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: rf7 = 7'h0;
        1: rf7 = F7_ALT;
        default: rf7 = F7_MULDIV;
      endcase
      run_op($sformatf("rnd%0d", i), ro, rf3, rf7, pick_operand(), pick_operand());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
